// File: rtl/signed_peak_window.sv
// signed_peak_window
//
// Streaming windowed peak detector for two's-complement samples. Accepts WINDOW samples on a
// valid/ready input, tracks the signed maximum (and optionally the minimum) with its position in
// the window, then holds one result record on a valid/ready output until it is consumed.
//
// Optional feature macro: PEAK_MIN_EN
//   defined   -> minimum tracking plus out_min, out_min_idx and out_p2p ports
//   undefined -> maximum tracking only
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   clear        in   synchronous abort of the window in progress or the held record
//   in_valid     in   sample offered
//   in_ready     out  block accepts a sample (high only while accumulating)
//   in_data      in   signed sample, WIDTH bits
//   out_valid    out  result record held
//   out_ready    in   consumer takes the record
//   out_max      out  signed window maximum
//   out_max_idx  out  0-based window position of out_max (latest on ties)
//   out_min      out  signed window minimum (PEAK_MIN_EN)
//   out_min_idx  out  0-based window position of out_min, earliest on ties (PEAK_MIN_EN)
//   out_p2p      out  unsigned max - min, WIDTH+1 bits (PEAK_MIN_EN)

module signed_peak_window #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned WINDOW = 16,
    parameter int unsigned IW     = (WINDOW > 1) ? $clog2(WINDOW) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [IW-1:0]    out_max_idx
`ifdef PEAK_MIN_EN
    ,
    output logic [WIDTH-1:0] out_min,
    output logic [IW-1:0]    out_min_idx,
    output logic [WIDTH:0]   out_p2p
`endif
);

    typedef enum logic {
        StAcc  = 1'b0,
        StHold = 1'b1
    } state_e;

    localparam logic [IW-1:0] LastIdx = IW'(WINDOW - 1);

    state_e           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [IW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_max;
    logic [IW-1:0]    r_max_idx;

    logic w_accept;
    logic w_first;
    logic w_last;
    logic w_max_upd;

    assign w_accept  = in_valid && r_in_ready;
    assign w_first   = (r_cnt == '0);
    assign w_last    = (r_cnt == LastIdx);
    // >= so that ties move the max index to the latest position
    assign w_max_upd = w_first || ($signed(in_data) >= $signed(r_max));

`ifdef PEAK_MIN_EN
    logic [WIDTH-1:0] r_min;
    logic [IW-1:0]    r_min_idx;
    logic             w_min_upd;

    // strict < so that ties keep the earliest min index
    assign w_min_upd = w_first || ($signed(in_data) < $signed(r_min));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StAcc;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
            r_max       <= '0;
            r_max_idx   <= '0;
`ifdef PEAK_MIN_EN
            r_min       <= '0;
            r_min_idx   <= '0;
`endif
        end else if (clear) begin
            // record contents are left as-is; they are meaningless until the next out_valid
            r_state     <= StAcc;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                StAcc: begin
                    // in_ready tracks the state so it becomes 1 on the first edge after reset
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        if (w_max_upd) begin
                            r_max     <= in_data;
                            r_max_idx <= r_cnt;
                        end
`ifdef PEAK_MIN_EN
                        if (w_min_upd) begin
                            r_min     <= in_data;
                            r_min_idx <= r_cnt;
                        end
`endif
                        if (w_last) begin
                            r_state     <= StHold;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_cnt       <= '0;
                        end else begin
                            r_cnt <= r_cnt + IW'(1);
                        end
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        r_state     <= StAcc;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= StAcc;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_max     = r_max;
    assign out_max_idx = r_max_idx;

`ifdef PEAK_MIN_EN
    assign out_min     = r_min;
    assign out_min_idx = r_min_idx;
    // sign-extended difference cannot overflow WIDTH+1 bits and is never negative
    assign out_p2p     = {r_max[WIDTH-1], r_max} - {r_min[WIDTH-1], r_min};
`endif

endmodule

// File: doc/signed_peak_window.md
# signed_peak_window

Streaming windowed peak detector for two's-complement samples. It consumes a valid/ready sample stream, tracks the signed maximum (and optionally the minimum) over fixed windows of `WINDOW` accepted samples, and presents one result record per window on a valid/ready output. It sits directly downstream of the signed `>=` magnitude comparison stage, using that same signed greater-than-or-equal decision, and feeds threshold/alarm logic.

## Interface
Parameters:
- `WIDTH`, 8: sample width, two's complement.
- `WINDOW`, 16: samples per window; legal range 1..256.
- `IW`, derived `max(1,$clog2(WINDOW))`: index width.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous abort: discard the window in progress or held.
- `in_valid`  in  1  sample offered.
- `in_ready`  out  1  block can accept a sample.
- `in_data`  in  WIDTH  signed sample.
- `out_valid`  out  1  result record held.
- `out_ready`  in  1  consumer accepts the record.
- `out_max`  out  WIDTH  signed window maximum.
- `out_max_idx`  out  IW  window position (0-based) of `out_max`.
- `out_min`  out  WIDTH  signed window minimum (`PEAK_MIN_EN` only).
- `out_min_idx`  out  IW  position of `out_min` (`PEAK_MIN_EN` only).
- `out_p2p`  out  WIDTH+1  unsigned `max - min` (`PEAK_MIN_EN` only).

## Operation
- Two-state FSM, `ACC` and `HOLD`. Reset state is `ACC`.
- Reset values: `in_ready=0` while `rst_n` is low, then 1 in `ACC`. `out_valid=0`. All data and index outputs are 0. Sample counter is 0.
- In `ACC`, `in_ready=1`. A sample is accepted when `in_valid && in_ready`.
- Sample 0 of a window loads max and min unconditionally; both indices are set to 0.
- Samples 1..WINDOW-1:
  - If `in_data >= max` (signed), update max and `max_idx`. Ties therefore move to the latest position.
  - If `in_data < min` (signed), update min and `min_idx`. Ties keep the earliest position.
- Accepting sample WINDOW-1 moves the FSM to `HOLD`, sets `out_valid=1`, and resets the counter to 0. The accepted sample is included in the result.
- In `HOLD`, `in_ready=0` and outputs are stable. When `out_valid && out_ready`, return to `ACC`.
- Arithmetic: `out_p2p = sign-extend(max) - sign-extend(min)` in WIDTH+1 bits. It never overflows and is always ≥ 0.
- Comparisons are signed, so 0x80 (-128) is the smallest 8-bit value and 0x7F is the largest.
- `clear` takes priority over everything else:
  - Next state is `ACC` with counter 0 and `out_valid=0`.
  - A sample accepted in the `clear` cycle is discarded.
  - Record contents are not cleared (they are don't-care until the next `out_valid`).
- `WINDOW=1`: every accepted sample produces a record with idx 0 and `p2p=0`.

## Timing
- `out_valid` rises the cycle after the final window sample is accepted (1-cycle latency).
- Output records are registered; no combinational path from `in_*` to `out_*`.
- `in_ready` is a function of FSM state only; there is no combinational path from `out_ready`.
- Throughput: WINDOW accepted samples plus at least 1 handshake cycle per window. The cycle in which `out_ready` completes the handshake does not accept input; `ACC` resumes the next cycle.
- `in_valid` gaps stall accumulation indefinitely and the counter holds.
- `rst_n` asserted mid-window or mid-`HOLD` forces all reset values immediately, without waiting for a clock edge.

## Configuration
- `PEAK_MIN_EN` defined: min tracking, `out_min`, `out_min_idx`, and `out_p2p` are present.
- `PEAK_MIN_EN` undefined: those ports and their registers are removed, and only max tracking remains. All timing is unchanged.

## Test plan
- WIDTH=8, WINDOW=4, samples 0x05, 0xFB, 0x7F, 0x80 back-to-back with `out_ready=1` → `out_max=0x7F` idx 2, `out_min=0x80` idx 3, `out_p2p=0x0FF`. `out_valid` is high exactly one cycle, the cycle after 0x80 is accepted.
- Ties: samples 0x10, 0x10, 0xF0, 0xF0 → `max_idx=1`, `min_idx=2`, `p2p=0x020`.
- Backpressure: complete a window with `out_ready=0` for 5 cycles → `in_ready=0` and record stable for all 5 cycles. Raising `out_ready` gives one handshake, then `in_ready=1` the next cycle.
- Gapped input: 4 samples with random `in_valid` gaps of 0-3 cycles → same record as the back-to-back case for the same samples.
- `clear` pulsed after 2 of 4 samples, then 4 new samples 0x01..0x04 → record `max=0x04` idx 3, `min=0x01` idx 0. The first 2 samples are excluded.
- `rst_n` pulsed low asynchronously during `HOLD` → `out_valid=0` and all outputs 0 before the next edge. The next window reports only post-reset samples.
